// File: rtl/idex_skid_stage.sv
// ID/EX pipeline register built as a two-entry skid buffer.
// Handshake: an entry moves when valid and ready are both high at a rising
// edge. in_ready is a flop, so it never depends on out_ready in the same cycle.
// The main register is the head. The skid register catches one extra entry
// while downstream stalls. occ exposes the FSM state: 0 EMPTY, 1 ONE, 2 FULL.
module idex_skid_stage #(
    parameter int DATA_W  = 8,
    parameter int RADDR_W = 3,
    parameter int ALUOP_W = 4,
    parameter int CONST_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUOP_W-1:0] alu_op_i,
    input  logic [DATA_W-1:0]  data1_i,
    input  logic [DATA_W-1:0]  data2_i,
    input  logic [RADDR_W-1:0] rd_i,
    input  logic [RADDR_W-1:0] rs1_i,
    input  logic [RADDR_W-1:0] rs2_i,
    input  logic               memRead_i,
    input  logic               memWrite_i,
    input  logic               regWrite_i,
    input  logic [CONST_W-1:0] constant_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic [DATA_W-1:0]  data1_o,
    output logic [DATA_W-1:0]  data2_o,
    output logic [RADDR_W-1:0] rd_o,
    output logic [RADDR_W-1:0] rs1_o,
    output logic [RADDR_W-1:0] rs2_o,
    output logic               memRead_o,
    output logic               memWrite_o,
    output logic               regWrite_o,
    output logic [CONST_W-1:0] constant_o,
    output logic [1:0]         occ
);

    localparam int ENTRY_W = ALUOP_W + 2*DATA_W + 3*RADDR_W + 3 + CONST_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t               state_q;
    logic [ENTRY_W-1:0]   main_q;
    logic [ENTRY_W-1:0]   skid_q;
    logic [ENTRY_W-1:0]   in_entry;
    logic                 main_valid_q;
    logic                 skid_valid_q;
    logic                 in_ready_q;
    logic                 push;
    logic                 pop;
    logic                 main_mem_read;
    logic                 main_mem_write;
    logic                 main_reg_write;

    // Pack all incoming fields into one entry word, unmodified.
    assign in_entry = {alu_op_i, data1_i, data2_i, rd_i, rs1_i, rs2_i,
                       memRead_i, memWrite_i, regWrite_i, constant_i};

    assign push = in_valid & in_ready_q;
    assign pop  = main_valid_q & out_ready;

    // Head entry drives the outputs straight from the main register.
    assign {alu_op_o, data1_o, data2_o, rd_o, rs1_o, rs2_o,
            main_mem_read, main_mem_write, main_reg_write, constant_o} = main_q;

    // Side-effecting controls are zeroed while no head is present (bubble).
    assign memRead_o  = main_mem_read  & main_valid_q;
    assign memWrite_o = main_mem_write & main_valid_q;
    assign regWrite_o = main_reg_write & main_valid_q;

    assign out_valid = main_valid_q;
    assign in_ready  = in_ready_q;
    assign occ       = state_q;

    // Occupancy FSM with main/skid storage; flush outranks push and pop.
    // On flush and on pop-to-empty the data stays put, so the outputs hold their last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_EMPTY;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            main_q       <= '0;
            skid_q       <= '0;
        end else if (flush) begin
            state_q      <= S_EMPTY;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        main_q       <= in_entry;
                        main_valid_q <= 1'b1;
                        state_q      <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        main_q <= in_entry;
                    end else if (push) begin
                        skid_q       <= in_entry;
                        skid_valid_q <= 1'b1;
                        in_ready_q   <= 1'b0;
                        state_q      <= S_FULL;
                    end else if (pop) begin
                        main_valid_q <= 1'b0;
                        state_q      <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    // in_ready is low here, so no push can arrive.
                    if (pop) begin
                        main_q       <= skid_q;
                        skid_valid_q <= 1'b0;
                        in_ready_q   <= 1'b1;
                        state_q      <= S_ONE;
                    end
                end
                default: begin
                    state_q      <= S_EMPTY;
                    main_valid_q <= 1'b0;
                    skid_valid_q <= 1'b0;
                    in_ready_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/idex_skid_stage.md
IDEX_SKID_STAGE -- requirements
Module: idex_skid_stage

Interface
REQ-001 The module SHALL have the following parameters:
- DATA_W, default 8: operand data width.
- RADDR_W, default 3: register-address width.
- ALUOP_W, default 4: ALU opcode width.
- CONST_W, default 2: constant-select width.

REQ-002 The module SHALL have one clock; reset is asynchronous and active-high. Port names are clk and reset.

REQ-003 The module SHALL have the following ports, in this order:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous discard of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry.
- alu_op_i  in  ALUOP_W  ALU opcode.
- data1_i  in  DATA_W  operand 1.
- data2_i  in  DATA_W  operand 2.
- rd_i  in  RADDR_W  destination register.
- rs1_i  in  RADDR_W  source register 1.
- rs2_i  in  RADDR_W  source register 2.
- memRead_i  in  1  load control.
- memWrite_i  in  1  store control.
- regWrite_i  in  1  register writeback control.
- constant_i  in  CONST_W  constant select.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream accepts head.
- alu_op_o, data1_o, data2_o, rd_o, rs1_o, rs2_o, memRead_o, memWrite_o, regWrite_o, constant_o  out  widths as inputs  head entry fields.
- occ  out  2  entries held (0..2).

Function
REQ-004 Storage SHALL be two full-entry registers, main (head) and skid, each with a valid bit.
- State EMPTY: none valid.
- State ONE: main valid.
- State FULL: main and skid valid.
- occ SHALL equal 0/1/2 for EMPTY/ONE/FULL.

REQ-005 in_ready SHALL be a registered function equal to (state != FULL); it SHALL NOT depend combinationally on out_ready.

REQ-006 push = in_valid & in_ready; pop = out_valid & out_ready; out_valid SHALL equal main valid.

REQ-007 Transitions without flush:
- EMPTY + push -> ONE, main loaded.
- ONE + push + pop -> ONE, main loaded with the new entry.
- ONE + push, no pop -> FULL, skid loaded.
- ONE + pop, no push -> EMPTY.
- FULL + pop -> ONE, main loaded from skid.
- No event -> hold.

REQ-008 Entries SHALL leave in arrival order, unmodified, one per pop, with no duplication or loss.

REQ-009 Latency SHALL be 1 cycle: an entry pushed at edge N is on the outputs with out_valid=1 after edge N when the stage was EMPTY, or when it was ONE with a pop in that cycle.

REQ-010 While out_valid=0, memRead_o, memWrite_o and regWrite_o SHALL be 0 (bubble). All other outputs SHALL hold their last value.

REQ-011 flush=1 at an edge SHALL force state EMPTY. Any push in that same cycle SHALL be discarded, and a pop in that same cycle SHALL still count as delivered downstream. flush SHALL have priority over push and pop.

REQ-012 The module SHALL have no combinational path from any *_i input to any *_o output.

REQ-013 Data fields SHALL be unsigned, passed bit-exact with no arithmetic and no truncation at any parameter setting.

Reset
REQ-014 While reset=1, state SHALL be EMPTY regardless of clk, with occ=0, out_valid=0 and in_ready=1.

REQ-015 Reset values of the data outputs:
- alu_op_o, data1_o, data2_o, rd_o, rs1_o, rs2_o, constant_o = 0.
- memRead_o, memWrite_o, regWrite_o = 0.

REQ-016 reset asserted mid-operation SHALL discard all held entries immediately (asynchronously). Operation SHALL resume on the first rising edge after deassertion.

Verification
REQ-017 Reset then single push: push data1_i=0x3C, rd_i=5, regWrite_i=1 with out_ready=1. Required: next cycle out_valid=1, data1_o=0x3C, rd_o=5, regWrite_o=1, occ=1. Following cycle occ=0 and regWrite_o=0.

REQ-018 Backpressure fill: with out_ready=0, push A=0x11 then B=0x22. Required: occ=2 and in_ready=0. Raising out_ready then yields A on the next cycle and B on the cycle after, in_ready returns to 1, and occ steps 2->1->0.

REQ-019 Streaming: push 0x01..0x10 on consecutive cycles with out_ready=1. Required: 16 outputs in order, one per cycle, occ constant at 1, in_ready never 0.

REQ-020 Flush: in FULL, assert flush with in_valid=1 and data 0x55. Required: next cycle occ=0, out_valid=0, memWrite_o=0, and 0x55 never appears on the outputs.

REQ-021 Async reset mid-stream: in FULL, pulse reset between clock edges. Required: occ=0, out_valid=0 and in_ready=1 before the next edge, and all outputs equal to the REQ-015 values.

REQ-022 Parameter sweep: DATA_W=16, RADDR_W=5. Push data1_i=0xBEEF, rs2_i=31. Required: data1_o=0xBEEF and rs2_o=31 exactly.
